// File: rtl/mtsp_alu_funpack.sv
// MTSP ALU pixel unpack: one packed RGB565 pair in, two RGB888 dwords out on consecutive beats.
// Optional constant alpha byte in DOUT[31:24] when MTSP_FUNPACK_ALPHA_EN is defined.
module mtsp_alu_funpack #(
    parameter int           OP_W   = 6,
    parameter logic [5:0]   OP_FMT = 6'h1C,
    parameter logic [7:0]   ALPHA  = 8'hFF
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            MO_nEN,
    input  logic [OP_W-1:0] MO_OP,
    input  logic            MO_ALT,
    input  logic [31:0]     SRCA,
    output logic            IN_READY,
    output logic            PHASE_EN,
    output logic            PHASE_LAST,
    output logic [31:0]     DOUT,
    output logic            ERR_OVF
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HI   = 2'd1,
        S_LO   = 2'd2
    } state_t;

`ifdef MTSP_FUNPACK_ALPHA_EN
    localparam logic [7:0] ALPHA_BYTE = ALPHA;
`else
    localparam logic [7:0] ALPHA_BYTE = ALPHA & 8'h00;
`endif

    // MSB replication keeps 0 -> 0x00 and full scale -> 0xFF exact.
    function automatic logic [23:0] expand565(input logic [15:0] c);
        logic [4:0] r5;
        logic [5:0] g6;
        logic [4:0] b5;
        r5 = c[15:11];
        g6 = c[10:5];
        b5 = c[4:0];
        return {r5, r5[4:2], g6, g6[5:4], b5, b5[4:2]};
    endfunction

    state_t      state_q, state_d;
    logic [31:0] p_q, p_d;
    logic        pv_q, pv_d;
    logic [15:0] w_q, w_d;
    logic [31:0] dout_q, dout_d;
    logic        phase_en_q, phase_en_d;
    logic        phase_last_q, phase_last_d;
    logic        err_ovf_q, err_ovf_d;

    logic        op_hit;
    logic        in_ready;
    logic        acc;

    assign op_hit   = ~MO_nEN & (MO_OP == OP_W'(OP_FMT)) & ~MO_ALT;
    assign in_ready = ~pv_q | (state_q != S_HI);
    assign acc      = op_hit & in_ready;

    always_comb begin
        state_d      = state_q;
        p_d          = p_q;
        pv_d         = pv_q;
        w_d          = w_q;
        dout_d       = dout_q;
        phase_en_d   = 1'b0;
        phase_last_d = 1'b0;
        err_ovf_d    = err_ovf_q;

        case (state_q)
            S_HI: begin
                dout_d       = {ALPHA_BYTE, expand565(w_q)};
                phase_en_d   = 1'b1;
                phase_last_d = 1'b1;
                state_d      = S_LO;
            end
            default: begin
                if (pv_q) begin
                    dout_d     = {ALPHA_BYTE, expand565(p_q[31:16])};
                    w_d        = p_q[15:0];
                    pv_d       = 1'b0;
                    phase_en_d = 1'b1;
                    state_d    = S_HI;
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase

        // A new op may land on the same edge the pending word is consumed.
        if (acc) begin
            p_d  = SRCA;
            pv_d = 1'b1;
        end

        if (op_hit && !in_ready) begin
            err_ovf_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= S_IDLE;
            p_q          <= 32'h0;
            pv_q         <= 1'b0;
            w_q          <= 16'h0;
            dout_q       <= 32'h0;
            phase_en_q   <= 1'b0;
            phase_last_q <= 1'b0;
            err_ovf_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            p_q          <= p_d;
            pv_q         <= pv_d;
            w_q          <= w_d;
            dout_q       <= dout_d;
            phase_en_q   <= phase_en_d;
            phase_last_q <= phase_last_d;
            err_ovf_q    <= err_ovf_d;
        end
    end

    assign IN_READY   = in_ready;
    assign PHASE_EN   = phase_en_q;
    assign PHASE_LAST = phase_last_q;
    assign DOUT       = dout_q;
    assign ERR_OVF    = err_ovf_q;

endmodule

// File: tb/tb_mtsp_alu_funpack.sv
// Scoreboard bench for mtsp_alu_funpack: stimulus pushes expected beats, a negedge monitor pops and compares.
module tb_mtsp_alu_funpack;

    localparam logic [5:0] OP_FMT = 6'h1C;
`ifdef MTSP_FUNPACK_ALPHA_EN
    localparam logic [7:0] EXP_A = 8'hFF;
`else
    localparam logic [7:0] EXP_A = 8'h00;
`endif

    logic        CLK = 1'b0;
    logic        RST;
    logic        MO_nEN;
    logic [5:0]  MO_OP;
    logic        MO_ALT;
    logic [31:0] SRCA;
    logic        IN_READY;
    logic        PHASE_EN;
    logic        PHASE_LAST;
    logic [31:0] DOUT;
    logic        ERR_OVF;

    int checks   = 0;
    int failures = 0;

    logic [32:0] exp_q[$];
    int          run_len = 0;
    int          run_max = 0;
    logic        prev_en = 1'b0;

    mtsp_alu_funpack #(.OP_W(6), .OP_FMT(OP_FMT), .ALPHA(8'hFF)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .MO_nEN     (MO_nEN),
        .MO_OP      (MO_OP),
        .MO_ALT     (MO_ALT),
        .SRCA       (SRCA),
        .IN_READY   (IN_READY),
        .PHASE_EN   (PHASE_EN),
        .PHASE_LAST (PHASE_LAST),
        .DOUT       (DOUT),
        .ERR_OVF    (ERR_OVF)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic push(input logic last, input logic [23:0] rgb);
        exp_q.push_back({last, EXP_A, rgb});
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic issue(input logic [31:0] s);
        MO_nEN = 1'b0;
        MO_OP  = OP_FMT;
        MO_ALT = 1'b0;
        SRCA   = s;
        @(posedge CLK);
        #1;
        MO_nEN = 1'b1;
    endtask

    // Monitor: every valid beat must match the head of the expected queue.
    always @(negedge CLK) begin
        if (PHASE_EN === 1'b1) begin
            logic [32:0] e;
            run_len = prev_en ? run_len + 1 : 1;
            if (run_len > run_max) run_max = run_len;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL beat_unexpected actual=%h last=%b required=none", DOUT, PHASE_LAST);
            end else begin
                e = exp_q.pop_front();
                if (DOUT !== e[31:0] || PHASE_LAST !== e[32]) begin
                    failures++;
                    $display("FAIL beat actual=%h last=%b required=%h last=%b",
                             DOUT, PHASE_LAST, e[31:0], e[32]);
                end
            end
        end
        prev_en = (PHASE_EN === 1'b1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST    = 1'b1;
        MO_nEN = 1'b0;
        MO_OP  = OP_FMT;
        MO_ALT = 1'b0;
        SRCA   = 32'hFFFF_FFFF;
        cyc(3);
        RST    = 1'b0;
        MO_nEN = 1'b1;
        @(negedge CLK);
        chk("rst_phase_en",   {31'd0, PHASE_EN},   32'd0);
        chk("rst_phase_last", {31'd0, PHASE_LAST}, 32'd0);
        chk("rst_dout",       DOUT,                32'h0);
        chk("rst_in_ready",   {31'd0, IN_READY},   32'd1);
        chk("rst_err_ovf",    {31'd0, ERR_OVF},    32'd0);
        cyc(3);

        // Single op: pure red then pure green.
        push(1'b0, 24'hFF0000);
        push(1'b1, 24'h00FF00);
        issue(32'hF800_07E0);
        cyc(3);
        @(negedge CLK);
        chk("single_idle_en",    {31'd0, PHASE_EN}, 32'd0);
        chk("single_dout_hold",  DOUT,              {EXP_A, 24'h00FF00});
        cyc(1);

        // Ignored ops: ALT=1, disabled, wrong opcode.
        MO_nEN = 1'b0; MO_ALT = 1'b1; MO_OP = OP_FMT; SRCA = 32'hFFFF_FFFF;
        cyc(1);
        MO_ALT = 1'b0; MO_nEN = 1'b1;
        cyc(1);
        MO_nEN = 1'b0; MO_OP = 6'h1D;
        cyc(1);
        MO_nEN = 1'b1; MO_OP = OP_FMT;
        cyc(3);
        @(negedge CLK);
        chk("ignore_en",       {31'd0, PHASE_EN}, 32'd0);
        chk("ignore_dout",     DOUT,              {EXP_A, 24'h00FF00});
        chk("ignore_err_ovf",  {31'd0, ERR_OVF},  32'd0);
        chk("ignore_in_ready", {31'd0, IN_READY}, 32'd1);
        cyc(1);

        // Full-scale blue then white; mid-scale.
        push(1'b0, 24'h0000FF);
        push(1'b1, 24'hFFFFFF);
        issue(32'h001F_FFFF);
        cyc(3);
        push(1'b0, 24'h848284);
        push(1'b1, 24'h000000);
        issue(32'h8410_0000);
        cyc(3);

        // Back-to-back every two cycles: six contiguous beats.
        run_max = 0;
        push(1'b0, 24'h1045A5); push(1'b1, 24'h52CFC6);
        push(1'b0, 24'h9C55E7); push(1'b1, 24'hDEDF84);
        push(1'b0, 24'hFFFFFF); push(1'b1, 24'h000000);
        issue(32'h1234_5678);
        cyc(1);
        issue(32'h9ABC_DEF0);
        cyc(1);
        issue(32'hFFFF_0000);
        cyc(7);
        chk("b2b_run_len", run_max,               32'd6);
        chk("b2b_err_ovf", {31'd0, ERR_OVF},      32'd0);
        chk("b2b_drained", exp_q.size(),          32'd0);

        // Consecutive-cycle issue: third op overflows and is dropped.
        push(1'b0, 24'hFF0000); push(1'b1, 24'h00FF00);
        push(1'b0, 24'h0000FF); push(1'b1, 24'hFFFFFF);
        MO_nEN = 1'b0; MO_OP = OP_FMT; MO_ALT = 1'b0; SRCA = 32'hF800_07E0;
        cyc(1);
        SRCA = 32'h001F_FFFF;
        cyc(1);
        chk("ovf_in_ready_low", {31'd0, IN_READY}, 32'd0);
        SRCA = 32'h8410_0000;
        cyc(1);
        MO_nEN = 1'b1;
        chk("ovf_err_set", {31'd0, ERR_OVF}, 32'd1);
        cyc(5);
        chk("ovf_err_sticky", {31'd0, ERR_OVF}, 32'd1);
        chk("ovf_drained",    exp_q.size(),     32'd0);

        // Reset while the high beat is on the output: low beat must never appear.
        push(1'b0, 24'h9C55E7);
        issue(32'h9ABC_DEF0);
        cyc(1);
        RST = 1'b1;
        cyc(1);
        RST = 1'b0;
        @(negedge CLK);
        chk("midrst_en",       {31'd0, PHASE_EN}, 32'd0);
        chk("midrst_dout",     DOUT,              32'h0);
        chk("midrst_in_ready", {31'd0, IN_READY}, 32'd1);
        chk("midrst_err_ovf",  {31'd0, ERR_OVF},  32'd0);
        cyc(3);

        push(1'b0, 24'h1045A5);
        push(1'b1, 24'h52CFC6);
        issue(32'h1234_5678);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc(1);
        cyc(2);
        chk("final_drained", exp_q.size(), 32'd0);
        chk("final_err_ovf", {31'd0, ERR_OVF}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
